pe_result_drain: RTL and testbench

Output-side collector for a row of MAC processing elements. It snapshots the signed accumulator outputs of NUM_PE processing elements on a single capture pulse and then streams them out one at a time, index 0 first, over a valid/ready interface. This frees the PE row to start its next accumulation while the previous results drain. It sits between the PE row and the result writeback / memory path.

---
 rtl/pe_result_drain.sv | 199 +++++++++++++++++++
 tb/tb_pe_result_drain.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_drain.sv
// pe_result_drain
//   Snapshots the signed accumulators of a row of NUM_PE MAC processing
//   elements on a one-cycle capture pulse, then streams them out one per
//   handshake, PE 0 first, over a valid/ready port. The PE row is free to
//   start its next accumulation while the previous results drain.
//
// Optional feature (compile-time macro PE_DRAIN_REQUANT_EN):
//   When defined, each element is requantized on its way out. The element is
//   arithmetically right-shifted by the shift value latched at capture, then
//   saturated to a signed OUT_WIDTH range and sign-extended back to
//   ACC_WIDTH. When undefined, the raw accumulator value is emitted and the
//   shift input is ignored.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   acc_in   in   NUM_PE*ACC_WIDTH flattened PE results, PE k at [k*ACC_WIDTH +: ACC_WIDTH]
//   capture  in   one-cycle snapshot request
//   shift    in   requantization shift, sampled with capture
//   busy     out  high while a snapshot is draining
//   m_valid  out  output element valid (equals busy)
//   m_ready  in   downstream accepts the element
//   m_data   out  output element (signed, registered)
//   m_idx    out  PE index of the current element
//   m_last   out  high with element NUM_PE-1
//   overrun  out  one-cycle pulse after a rejected capture
module pe_result_drain #(
  parameter int ACC_WIDTH   = 32,
  parameter int NUM_PE      = 8,
  parameter int IDX_WIDTH   = 3,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PE*ACC_WIDTH-1:0] acc_in,
  input  logic                        capture,
  input  logic [SHIFT_WIDTH-1:0]      shift,
  output logic                        busy,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [ACC_WIDTH-1:0]        m_data,
  output logic [IDX_WIDTH-1:0]        m_idx,
  output logic                        m_last,
  output logic                        overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PE - 1);

  state_t                       state_q, state_d;
  logic [IDX_WIDTH-1:0]         idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]  m_data_q, m_data_d;
  logic                         overrun_q, overrun_d;
  logic signed [ACC_WIDTH-1:0]  shadow_q [NUM_PE];
  logic signed [ACC_WIDTH-1:0]  shadow_d [NUM_PE];
  logic signed [ACC_WIDTH-1:0]  acc_slice [NUM_PE];

  logic [IDX_WIDTH-1:0]         idx_nxt;
  logic                         handshake;
  logic                         at_last;
  logic                         load;
  logic signed [ACC_WIDTH-1:0]  first_val;
  logic signed [ACC_WIDTH-1:0]  next_val;

  always_comb begin
    for (int k = 0; k < NUM_PE; k++) begin
      acc_slice[k] = acc_in[k*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  assign idx_nxt   = idx_q + 1'b1;
  assign handshake = (state_q == SEND) && m_ready;
  assign at_last   = (idx_q == LAST_IDX);

`ifdef PE_DRAIN_REQUANT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    ACC_WIDTH'(-(longint'(1) <<< (OUT_WIDTH - 1)));

  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;

  // Floor-shift then clamp. Shifts at or beyond the accumulator width
  // collapse to the sign (0 or -1), which the clamp then passes through.
  function automatic logic signed [ACC_WIDTH-1:0] requant(
    input logic signed [ACC_WIDTH-1:0] acc,
    input logic [SHIFT_WIDTH-1:0]      sh
  );
    logic signed [ACC_WIDTH-1:0] t;
    if (int'(sh) >= ACC_WIDTH) begin
      t = acc[ACC_WIDTH-1] ? '1 : '0;
    end else begin
      t = acc >>> sh;
    end
    if (t > SAT_MAX) begin
      return SAT_MAX;
    end else if (t < SAT_MIN) begin
      return SAT_MIN;
    end else begin
      return t;
    end
  endfunction

  // The first element of a fresh snapshot uses the shift arriving with the
  // capture; later elements use the latched copy.
  assign first_val = requant(acc_slice[0], shift);
  assign next_val  = requant(shadow_q[idx_nxt], shift_q);
`else
  logic unused_shift;
  assign unused_shift = ^shift;
  assign first_val    = acc_slice[0];
  assign next_val     = shadow_q[idx_nxt];
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    m_data_d  = m_data_q;
    overrun_d = 1'b0;
    shadow_d  = shadow_q;
`ifdef PE_DRAIN_REQUANT_EN
    shift_d   = shift_q;
`endif
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        if (capture) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (!at_last) begin
            idx_d     = idx_nxt;
            m_data_d  = next_val;
            overrun_d = capture;
          end else if (capture) begin
            // Recapture on the final handshake keeps the stream gapless.
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          // Any capture while elements are still owed is dropped.
          overrun_d = capture;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shadow_d = acc_slice;
      idx_d    = '0;
      m_data_d = first_val;
`ifdef PE_DRAIN_REQUANT_EN
      shift_d  = shift;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      m_data_q  <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NUM_PE; k++) begin
        shadow_q[k] <= '0;
      end
`ifdef PE_DRAIN_REQUANT_EN
      shift_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      m_data_q  <= m_data_d;
      overrun_q <= overrun_d;
      shadow_q  <= shadow_d;
`ifdef PE_DRAIN_REQUANT_EN
      shift_q   <= shift_d;
`endif
    end
  end

  assign busy    = (state_q == SEND);
  assign m_valid = busy;
  assign m_idx   = idx_q;
  assign m_last  = busy && at_last;
  assign m_data  = m_data_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pe_result_drain.sv
module tb_pe_result_drain;

  localparam int AW = 32;
  localparam int NP = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NP*AW-1:0]    acc_in;
  logic                capture;
  logic [4:0]          shift;
  logic                busy;
  logic                m_valid;
  logic                m_ready;
  logic signed [AW-1:0] m_data;
  logic [2:0]          m_idx;
  logic                m_last;
  logic                overrun;

  pe_result_drain dut (
    .clk     (clk),
    .rst     (rst),
    .acc_in  (acc_in),
    .capture (capture),
    .shift   (shift),
    .busy    (busy),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_idx   (m_idx),
    .m_last  (m_last),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [AW-1:0] d;
    int                   idx;
    bit                   last;
  } item_t;

  item_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    outstanding = 0;
  bit    ovr_pend = 0, ovr_cur = 0;
  bit    vld_pend = 0, vld_cur = 0;
  bit    started = 0, in_reset = 1;
  logic signed [AW-1:0] vals [NP];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: floor(acc / 2^sh), clamped to signed 8 bits.
  function automatic logic signed [AW-1:0] model(input logic signed [AW-1:0] a,
                                                 input logic [4:0] sh);
`ifdef PE_DRAIN_REQUANT_EN
    longint v, p, t;
    v = a;
    p = longint'(1) << sh;
    t = v / p;
    if ((v % p) != 0 && v < 0) t = t - 1;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return AW'(t);
`else
    return a;
`endif
  endfunction

  // Called just after a rising edge: drives inputs for the next edge and
  // advances the transaction-level model by what that edge will do.
  task automatic step(input bit cap, input bit rdy, input logic [4:0] sh);
    bit    hs, acc;
    item_t it;
    capture = cap;
    m_ready = rdy;
    shift   = sh;
    for (int k = 0; k < NP; k++) acc_in[k*AW +: AW] = vals[k];
    hs  = (outstanding > 0) && rdy;
    acc = cap && (outstanding == 0 || (outstanding == 1 && rdy));
    if (hs) outstanding--;
    if (acc) begin
      for (int k = 0; k < NP; k++) begin
        it.d    = model(vals[k], sh);
        it.idx  = k;
        it.last = (k == NP - 1);
        sb.push_back(it);
      end
      outstanding += NP;
    end
    ovr_pend = cap && !acc;
    vld_pend = (outstanding > 0);
    @(posedge clk);
    #1;
    ovr_cur = ovr_pend;
    vld_cur = vld_pend;
    capture = 1'b0;
  endtask

  // Monitor: samples on the falling edge, scores handshakes in order.
  item_t                it_m;
  bit                   prev_stall = 0;
  logic signed [AW-1:0] prev_d;
  logic [2:0]           prev_i;
  logic                 prev_l;

  always @(negedge clk) begin
    if (started && !in_reset) begin
      chk("overrun", overrun, ovr_cur);
      chk("m_valid", m_valid, vld_cur);
      chk("busy", busy, vld_cur);
      if (!m_valid) chk("m_last_idle", m_last, 0);
      if (m_valid && prev_stall) begin
        chk("stall_data", m_data, prev_d);
        chk("stall_idx", m_idx, prev_i);
        chk("stall_last", m_last, prev_l);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_elem", 1, 0);
        end else begin
          it_m = sb.pop_front();
          chk("m_data", m_data, it_m.d);
          chk("m_idx", m_idx, it_m.idx);
          chk("m_last", m_last, it_m.last);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_i     = m_idx;
      prev_l     = m_last;
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_idx"}, m_idx, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic rand_vals();
    for (int k = 0; k < NP; k++) begin
      case ($urandom_range(0, 5))
        0: vals[k] = 32'sh7fffffff;
        1: vals[k] = 32'sh80000000;
        2: vals[k] = $signed(32'($urandom_range(0, 600))) - 300;
        default: vals[k] = $signed($urandom());
      endcase
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; capture = 1'b0; m_ready = 1'b0; shift = '0; acc_in = '0;
    for (int k = 0; k < NP; k++) vals[k] = '0;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_reset = 1'b0;
    started = 1'b1;

    // Basic drain
    vals[0] = 7; vals[1] = -3; vals[2] = 100; vals[3] = 0;
    vals[4] = 1; vals[5] = 2;  vals[6] = 3;   vals[7] = 32'sh80000000;
    step(1, 1, 5'd0);
    repeat (10) step(0, 1, 5'd0);

    // Backpressure 1,0,0,1
    rand_vals();
    step(1, 1, 5'd3);
    for (int i = 0; i < 40; i++) step(0, (i % 4 == 0) || (i % 4 == 3), 5'd3);

    // Overrun at idx 3
    rand_vals();
    step(1, 1, 5'd2);
    repeat (3) step(0, 1, 5'd2);
    rand_vals();
    step(1, 1, 5'd7);
    repeat (8) step(0, 1, 5'd0);

    // Back-to-back recapture on the idx-7 handshake
    rand_vals();
    step(1, 1, 5'd1);
    repeat (7) step(0, 1, 5'd1);
    for (int k = 0; k < NP; k++) vals[k] = 5;
    step(1, 1, 5'd0);
    repeat (9) step(0, 1, 5'd0);

    // Reset mid-drain at idx 2
    rand_vals();
    step(1, 1, 5'd0);
    repeat (2) step(0, 1, 5'd0);
    in_reset = 1'b1;
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    outstanding = 0;
    ovr_cur = 0; vld_cur = 0; prev_stall = 0;
    in_reset = 1'b0;
    repeat (4) step(0, 1, 5'd0);

`ifdef PE_DRAIN_REQUANT_EN
    vals[0] = 1000; vals[1] = 5000; vals[2] = -5000; vals[3] = -17;
    vals[4] = 0;    vals[5] = 15;   vals[6] = -16;   vals[7] = -1;
    step(1, 1, 5'd4);
    repeat (9) step(0, 1, 5'd4);
    for (int k = 0; k < NP; k++) vals[k] = -1;
    vals[1] = 32'sh7fffffff; vals[2] = 32'sh80000000;
    step(1, 1, 5'd31);
    repeat (9) step(0, 1, 5'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rand_vals();
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 31)));
    end

    // Final drain
    for (int i = 0; i < 40 && outstanding > 0; i++) step(0, 1, 5'd0);
    repeat (2) step(0, 1, 5'd0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
